// File: rtl/switch_port_rx_if.sv
// switch_port_rx_if
//   Bundle of the switch-facing four-phase handshake and the sink-facing
//   valid/ready stream of one switch output port receiver.
//
//   Switch side : port_req, port_data (from switch), port_received (to switch)
//   Sink side   : out_data, out_valid (to sink), out_ready (from sink)
//   Status      : fifo_count (occupancy), word_count (words captured)
//
//   Modports
//     master : the environment (switch + sink) driving the receiver
//     slave  : the receiver itself
interface switch_port_rx_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int COUNT_WIDTH = 16
);
   logic                        port_req;
   logic [DATA_WIDTH-1:0]       port_data;
   logic                        port_received;
   logic [DATA_WIDTH-1:0]       out_data;
   logic                        out_valid;
   logic                        out_ready;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [COUNT_WIDTH-1:0]      word_count;

   modport master (
      output port_req, port_data, out_ready,
      input  port_received, out_data, out_valid, fifo_count, word_count
   );

   modport slave (
      input  port_req, port_data, out_ready,
      output port_received, out_data, out_valid, fifo_count, word_count
   );
endinterface

// File: rtl/switch_port_rx.sv
// switch_port_rx
//   Per-output-port receiver downstream of the switch. Captures words offered
//   on a four-phase req/received handshake into a show-ahead FIFO and presents
//   them to the sink as a valid/ready stream, counting captured words.
//
//   Ports
//     clk         : clock, rising edge
//     reset       : asynchronous assert, synchronous release, active high
//     bus         : switch_port_rx_if.slave (handshake, stream, status)
//     fsm_state   : debug view of the FSM (0 = IDLE, 1 = ACK)
//     stall_count : only with SWITCH_PORT_RX_STALL_STATS_EN; saturating count
//                   of cycles a request waited in IDLE on a full FIFO
//
//   Handshakes
//     Switch side: a word is captured on the edge where the FSM is IDLE,
//     port_req is high and the registered FIFO full flag is low; port_received
//     then stays high until port_req is sampled low.
//     Sink side: a word transfers on every rising edge where out_valid and
//     out_ready are both high; out_data is stable while out_valid is high and
//     out_ready is low.
//
//   Optional feature macro: SWITCH_PORT_RX_STALL_STATS_EN
module switch_port_rx #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   switch_port_rx_if.slave        bus,
   output logic                   fsm_state
`ifdef SWITCH_PORT_RX_STALL_STATS_EN
   ,
   output logic [COUNT_WIDTH-1:0] stall_count
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [PTR_W:0]          count_q;
   logic [DATA_WIDTH-1:0]   head_q;
   logic [COUNT_WIDTH-1:0]  word_count_q;
   logic                    full;
   logic                    push;
   logic                    pop;

   // Full is the registered occupancy, so a pop on this edge cannot free a
   // slot for a capture on the same edge.
   assign full = (count_q == DEPTH_C);
   assign pop  = (count_q != '0) && bus.out_ready;

   // FSM: next state and capture decision
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.port_req && !full) begin
               push    = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            if (!bus.port_req) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Storage array carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.port_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         head_q       <= '0;
         word_count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr       <= wr_ptr + 1'b1;
            word_count_q <= word_count_q + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count_q <= count_q + ONE_C;
            2'b01:   count_q <= count_q - ONE_C;
            default: count_q <= count_q;
         endcase

         // head_q is the show-ahead output register. It follows the entry that
         // will be at the head after this edge, and keeps the last word when
         // the FIFO drains.
         if (push && count_q == '0) begin
            head_q <= bus.port_data;
         end else if (pop) begin
            if (count_q > ONE_C) head_q <= mem[rd_ptr + 1'b1];
            else if (push)       head_q <= bus.port_data;
         end
      end
   end

`ifdef SWITCH_PORT_RX_STALL_STATS_EN
   logic [COUNT_WIDTH-1:0] stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else if (state_q == IDLE && bus.port_req && full && stall_q != '1) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_count = stall_q;
`endif

   // port_received is the ACK state itself, so reset clears it immediately.
   assign bus.port_received = (state_q == ACK);
   assign bus.out_data      = head_q;
   assign bus.out_valid     = (count_q != '0);
   assign bus.fifo_count    = count_q;
   assign bus.word_count    = word_count_q;
   assign fsm_state         = (state_q == ACK);

endmodule

// File: tb/tb_switch_port_rx.sv
// tb_switch_port_rx
//   Self-checking bench for switch_port_rx (DATA_WIDTH 8, FIFO_DEPTH 8,
//   COUNT_WIDTH 4 so word_count wrap is reachable quickly). A queue-based
//   model of the port tracks expected FIFO contents, acknowledge phase and
//   counters; a vector table and hand-written sequences add fixed checks.
module tb_switch_port_rx;

   localparam int DW        = 8;
   localparam int DEPTH     = 8;
   localparam int CW        = 4;
   localparam int WC_MOD    = 1 << CW;
   localparam int STALL_MAX = WC_MOD - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic fsm_state;
   always #5 clk = ~clk;

   switch_port_rx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .COUNT_WIDTH(CW)) bus ();

`ifdef SWITCH_PORT_RX_STALL_STATS_EN
   logic [CW-1:0] stall_count;
`endif

   switch_port_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .fsm_state  (fsm_state)
`ifdef SWITCH_PORT_RX_STALL_STATS_EN
      ,
      .stall_count(stall_count)
`endif
   );

   // ---------------- scoreboard / model ----------------
   int compared   = 0;
   int mismatched = 0;

   logic [DW-1:0] exp_q[$];   // words expected in the FIFO, head first
   logic [DW-1:0] sink_q[$];  // words the sink actually accepted from the DUT
   logic [DW-1:0] m_head;     // value out_data should show
   bit            m_ack;      // switch currently acknowledged
   int            m_wc;
   int            m_stall;
   int            max_fc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_head  = '0;
      m_ack   = 1'b0;
      m_wc    = 0;
      m_stall = 0;
   endtask

   // One clock edge of the port, from the rules: capture only when not already
   // acknowledged, requested and not full before this edge's pop.
   task automatic model_step(input logic req, input logic [DW-1:0] d, input logic rdy);
      int sz;
      bit full;
      bit cap;
      sz   = exp_q.size();
      full = (sz == DEPTH);
      cap  = !m_ack && req && !full;
      if (!m_ack && req && full && m_stall < STALL_MAX) m_stall++;
      if (sz > 0 && rdy) void'(exp_q.pop_front());
      if (cap) begin
         exp_q.push_back(d);
         m_wc = (m_wc + 1) % WC_MOD;
      end
      if (m_ack) m_ack = req;
      else       m_ack = cap;
      if (exp_q.size() > 0) m_head = exp_q[0];
   endtask

   task automatic check_model();
      check("port_received", 32'(bus.port_received), 32'(m_ack));
      check("out_valid",     32'(bus.out_valid),     32'(exp_q.size() != 0));
      check("fifo_count",    32'(bus.fifo_count),    32'(exp_q.size()));
      check("out_data",      32'(bus.out_data),      32'(m_head));
      check("word_count",    32'(bus.word_count),    32'(m_wc));
`ifdef SWITCH_PORT_RX_STALL_STATS_EN
      check("stall_count",   32'(stall_count),       32'(m_stall));
`endif
   endtask

   // ---------------- driver tasks ----------------
   // Called at a falling edge: drive, log sink transfer, step model, check.
   task automatic tick(input logic req, input logic [DW-1:0] d, input logic rdy);
      bus.port_req  = req;
      bus.port_data = d;
      bus.out_ready = rdy;
      #1;
      if (bus.out_valid && rdy) sink_q.push_back(bus.out_data);
      @(posedge clk);
      model_step(req, d, rdy);
      @(negedge clk);
      if (int'(bus.fifo_count) > max_fc) max_fc = int'(bus.fifo_count);
      check_model();
   endtask

   task automatic handshake(input logic [DW-1:0] d, input logic rdy);
      int n;
      n = 0;
      tick(1'b1, d, rdy);
      while (!bus.port_received && n < 40) begin
         tick(1'b1, d, rdy);
         n++;
      end
      if (n >= 40) check("handshake_ack_timeout", 32'(bus.port_received), 32'd1);
      n = 0;
      tick(1'b0, d, rdy);
      while (bus.port_received && n < 40) begin
         tick(1'b0, d, rdy);
         n++;
      end
      if (n >= 40) check("handshake_release_timeout", 32'(bus.port_received), 32'd0);
   endtask

   task automatic do_reset();
      bus.port_req  = 1'b0;
      bus.port_data = '0;
      bus.out_ready = 1'b0;
      #2 reset = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);
      check("rst_port_received", 32'(bus.port_received), 32'd0);
      check("rst_out_valid",     32'(bus.out_valid),     32'd0);
      check("rst_out_data",      32'(bus.out_data),      32'd0);
      check("rst_fifo_count",    32'(bus.fifo_count),    32'd0);
      check("rst_word_count",    32'(bus.word_count),    32'd0);
      check("rst_fsm_state",     32'(fsm_state),         32'd0);
      reset = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          req;
      logic [DW-1:0] data;
      logic          rdy;
      logic          e_recv;
      logic          e_valid;
      logic [DW-1:0] e_data;
      int            e_fc;
      int            e_wc;
   } vec_t;

   vec_t vecs[8];

   // ---------------- stimulus ----------------
   initial begin
      vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 1};
      vecs[1] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 1}; // data change in ACK ignored
      vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1};
      vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1, 2}; // push + pop together
      vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 0, 2}; // drains, data held
      vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 2};
      vecs[6] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h77, 1, 3}; // empty: no pop
      vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77, 1, 3};

      bus.port_req  = 1'b0;
      bus.port_data = '0;
      bus.out_ready = 1'b0;
      model_clear();
      max_fc = 0;
      @(negedge clk);

      // Single word and basic patterns
      do_reset();
      foreach (vecs[i]) begin
         tick(vecs[i].req, vecs[i].data, vecs[i].rdy);
         check($sformatf("vec%0d_recv", i),  32'(bus.port_received), 32'(vecs[i].e_recv));
         check($sformatf("vec%0d_valid", i), 32'(bus.out_valid),     32'(vecs[i].e_valid));
         check($sformatf("vec%0d_data", i),  32'(bus.out_data),      32'(vecs[i].e_data));
         check($sformatf("vec%0d_fc", i),    32'(bus.fifo_count),    32'(vecs[i].e_fc));
         check($sformatf("vec%0d_wc", i),    32'(bus.word_count),    32'(vecs[i].e_wc));
      end

      // Fill with out_ready low, then a blocked ninth request
      do_reset();
      sink_q.delete();
      for (int i = 1; i <= 8; i++) handshake(8'(i), 1'b0);
      check("fill_fc", 32'(bus.fifo_count), 32'd8);
      repeat (5) tick(1'b1, 8'h09, 1'b0);
      check("blocked_recv", 32'(bus.port_received), 32'd0);
      check("blocked_fc",   32'(bus.fifo_count),    32'd8);
`ifdef SWITCH_PORT_RX_STALL_STATS_EN
      check("stall_5", 32'(stall_count), 32'd5);
`endif
      tick(1'b1, 8'h09, 1'b1);   // pop while full: no capture yet
      check("pop_edge_recv", 32'(bus.port_received), 32'd0);
      check("pop_edge_fc",   32'(bus.fifo_count),    32'd7);
      check("pop_edge_head", 32'(bus.out_data),      32'h02);
      tick(1'b1, 8'h09, 1'b0);   // capture one cycle later
      check("late_cap_recv", 32'(bus.port_received), 32'd1);
      check("late_cap_fc",   32'(bus.fifo_count),    32'd8);
      check("late_cap_wc",   32'(bus.word_count),    32'd9);
      tick(1'b0, 8'h00, 1'b0);
      repeat (10) tick(1'b0, 8'h00, 1'b1);
      check("fill_sink_n", 32'(sink_q.size()), 32'd9);
      for (int i = 0; i < 9 && i < sink_q.size(); i++)
         check($sformatf("fill_sink%0d", i), 32'(sink_q[i]), 32'(i + 1));

      // Streaming with out_ready high
      do_reset();
      sink_q.delete();
      max_fc = 0;
      for (int i = 0; i < 20; i++) handshake(8'(8'h40 + i), 1'b1);
      check("stream_max_fc", 32'(max_fc <= 1), 32'd1);
      check("stream_wc",     32'(bus.word_count), 32'(20 % WC_MOD));
      check("stream_sink_n", 32'(sink_q.size()),  32'd20);
      for (int i = 0; i < 20 && i < sink_q.size(); i++)
         check($sformatf("stream_sink%0d", i), 32'(sink_q[i]), 32'(8'h40 + i));

      // word_count wrap
      do_reset();
      for (int i = 0; i < 15; i++) handshake(8'(i), 1'b1);
      check("wc_max", 32'(bus.word_count), 32'd15);
      handshake(8'hEE, 1'b1);
      check("wc_wrap", 32'(bus.word_count), 32'd0);

      // Reset in the middle of an acknowledge
      do_reset();
      tick(1'b1, 8'h42, 1'b0);
      tick(1'b1, 8'h42, 1'b0);
      check("midack_recv", 32'(bus.port_received), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_recv", 32'(bus.port_received), 32'd0);
      check("async_rst_fc",   32'(bus.fifo_count),    32'd0);
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      tick(1'b1, 8'h42, 1'b0);
      check("recap_recv", 32'(bus.port_received), 32'd1);
      check("recap_wc",   32'(bus.word_count),    32'd1);
      check("recap_data", 32'(bus.out_data),      32'h42);
      tick(1'b0, 8'h00, 1'b0);

`ifdef SWITCH_PORT_RX_STALL_STATS_EN
      // Saturation of stall_count
      do_reset();
      for (int i = 0; i < 8; i++) handshake(8'(i), 1'b0);
      repeat (STALL_MAX + 4) tick(1'b1, 8'h55, 1'b0);
      check("stall_sat", 32'(stall_count), 32'(STALL_MAX));
`endif

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         tick(1'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 99) < 45));
      end

      // ---------------- final report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
